// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser
// Converts a stream of ASCII characters into hexadecimal token values.
// Tokens are runs of hex digits separated by CR, LF or space; a token that
// contains an illegal character or more than MAX_DIGITS digits is reported
// with out_err = 1 and out_data = 0.
//
// Build option: define ASCII_HEX_PARSER_PREFIX_EN to accept an optional
// "0x"/"0X" prefix in front of a token. Left undefined, x/X are illegal.
//
// Parameters:
//   DATA_W      width of the parsed value (multiple of 4, >= 4)
//   MAX_DIGITS  maximum hex digits per token (1 .. DATA_W/4)
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    character present on in_data
//   in_data     ASCII character
//   in_ready    parser accepts a character (low only while a result waits)
//   out_valid   parsed result present
//   out_ready   consumer accepts the result
//   out_data    parsed value, first digit most significant
//   out_digits  number of digits in the token
//   out_err     token was malformed
module ascii_hex_parser #(
   parameter int DATA_W     = 32,
   parameter int MAX_DIGITS = DATA_W / 4,
   localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_digits,
   output logic              out_err
);

   typedef enum logic [1:0] {IDLE, ACCUM, SKIP, EMIT} state_t;

   state_t              state;
   logic [DATA_W-1:0]   acc;
   logic [CNT_W-1:0]    cnt;
   logic                is_digit;
   logic                is_term;
   logic [3:0]          digit;
   logic                accept;
   logic                cnt_full;
   logic [DATA_W-1:0]   acc_shift;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
   logic                prefix_seen;
   logic                is_x;
   logic                prefix_ok;
`endif

   // Character classification
   always_comb begin
      is_digit = 1'b0;
      digit    = 4'd0;
      if (in_data >= 8'h30 && in_data <= 8'h39) begin
         is_digit = 1'b1;
         digit    = in_data[3:0];
      end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                   (in_data >= 8'h61 && in_data <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
         is_digit = 1'b1;
         digit    = in_data[3:0] + 4'd9;
      end
   end

   assign is_term   = (in_data == 8'h0D) || (in_data == 8'h0A) || (in_data == 8'h20);
   assign in_ready  = (state != EMIT);
   assign accept    = in_valid && in_ready;
   assign cnt_full  = (cnt == CNT_W'(MAX_DIGITS));
   // Shift form works for DATA_W == 4 as well, where a part-select would not
   assign acc_shift = (acc << 4) | DATA_W'(digit);

`ifdef ASCII_HEX_PARSER_PREFIX_EN
   assign is_x      = (in_data == 8'h78) || (in_data == 8'h58);
   // acc == 0 with one digit means the token so far is exactly "0"
   assign prefix_ok = is_x && (cnt == CNT_W'(1)) && (acc == '0) && !prefix_seen;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_digits <= '0;
         out_err    <= 1'b0;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
         prefix_seen <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_digit) begin
                     acc   <= DATA_W'(digit);
                     cnt   <= CNT_W'(1);
                     state <= ACCUM;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
                     prefix_seen <= 1'b0;
`endif
                  end else if (!is_term) begin
                     state <= SKIP;
                  end
               end
            end

            ACCUM: begin
               if (accept) begin
`ifdef ASCII_HEX_PARSER_PREFIX_EN
                  if (prefix_ok) begin
                     acc         <= '0;
                     cnt         <= '0;
                     prefix_seen <= 1'b1;
                  end else
`endif
                  if (is_digit) begin
                     if (cnt_full) begin
                        state <= SKIP;
                     end else begin
                        acc <= acc_shift;
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else if (is_term) begin
                     state      <= EMIT;
                     out_valid  <= 1'b1;
                     out_data   <= acc;
                     out_digits <= cnt;
                     out_err    <= 1'b0;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
                     // bare "0x" has no digits and is malformed
                     if (cnt == '0) begin
                        out_data   <= '0;
                        out_digits <= '0;
                        out_err    <= 1'b1;
                     end
`endif
                  end else begin
                     state <= SKIP;
                  end
               end
            end

            SKIP: begin
               if (accept && is_term) begin
                  state      <= EMIT;
                  out_valid  <= 1'b1;
                  out_data   <= '0;
                  out_digits <= '0;
                  out_err    <= 1'b1;
               end
            end

            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Testbench for ascii_hex_parser: directed and random character streams,
// checked against a token-level model of the parsing rules.
module tb_ascii_hex_parser;

   localparam int DATA_W     = 32;
   localparam int MAX_DIGITS = 8;
   localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

   typedef byte unsigned bq_t[$];
   typedef struct {
      logic [DATA_W-1:0] val;
      int                digits;
      bit                err;
   } res_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  out_digits;
   logic              out_err;

   int checks   = 0;
   int failures = 0;
   int tok_no   = 0;

   ascii_hex_parser #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_digits (out_digits),
      .out_err    (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bit tb_is_term(input byte unsigned c);
      return (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
   endfunction

   // -1 for non-hex characters, else the digit value
   function automatic int hex_val(input byte unsigned c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      return -1;
   endfunction

   // Evaluate one complete (non-empty) token
   function automatic res_t model_tok(input bq_t t);
      res_t r;
      int   start = 0;
      int   d;
      r.val = '0; r.digits = 0; r.err = 0;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
      if (t.size() >= 2 && t[0] == "0" && (t[1] == "x" || t[1] == "X")) start = 2;
`endif
      for (int i = start; i < t.size(); i++) begin
         d = hex_val(t[i]);
         if (d < 0) r.err = 1;
         else begin
            r.digits++;
            r.val = r.val * 16 + DATA_W'(d);
         end
      end
      if (r.digits > MAX_DIGITS) r.err = 1;
      if (start == 2 && t.size() == 2) r.err = 1;
      if (r.err) begin
         r.val = '0; r.digits = 0;
      end
      return r;
   endfunction

   // Drive a stream and check every cycle. ready_pct < 0 holds out_ready
   // low for the first 5 cycles of each result.
   task automatic run_stream(input bq_t s, input int valid_pct, input int ready_pct,
                             output int cycles);
      res_t exp_q[$];
      bq_t  tok;
      int   idx = 0;
      int   tok_len = 0;
      bit   in_emit = 0;
      int   stall = 0;
      int   budget = 30 * s.size() + 100;
      bit   acc_c, hs;
      for (int i = 0; i < s.size(); i++) begin
         if (tb_is_term(s[i])) begin
            if (tok.size() > 0) exp_q.push_back(model_tok(tok));
            tok.delete();
         end else tok.push_back(s[i]);
      end
      cycles = 0;
      while ((idx < s.size() || exp_q.size() > 0 || in_emit) && cycles < budget) begin
         @(negedge clk);
         check("in_ready", in_ready, !in_emit);
         check("out_valid", out_valid, in_emit);
         if (in_emit && exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0].val);
            check("out_err", out_err, exp_q[0].err);
            if (!exp_q[0].err) check("out_digits", out_digits, exp_q[0].digits);
         end
         if (idx < s.size() && ($urandom % 100) < valid_pct) begin
            in_valid = 1'b1;
            in_data  = s[idx];
         end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end
         if (ready_pct < 0) out_ready = (stall >= 5);
         else out_ready = (($urandom % 100) < ready_pct);
         if (in_emit) stall++;
         acc_c = in_valid && in_ready;
         hs    = out_valid && out_ready;
         @(posedge clk);
         cycles++;
         if (hs) begin
            $display("token %0d: data=0x%0h digits=%0d err=%0d", tok_no, out_data, out_digits, out_err);
            tok_no++;
            if (exp_q.size() == 0) check("extra_result", 1, 0);
            else void'(exp_q.pop_front());
            in_emit = 0;
            stall   = 0;
         end
         if (acc_c) begin
            if (tb_is_term(s[idx])) begin
               if (tok_len > 0) in_emit = 1;
               tok_len = 0;
            end else tok_len++;
            idx++;
         end
      end
      if (cycles >= budget) check("timeout", 1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("idle_after", out_valid, 0);
   endtask

   task automatic run_str(input string s, input int vp, input int rp);
      int cyc;
      run_stream(s2q(s), vp, rp, cyc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_digits"}, out_digits, 0);
      check({tag, "_err"}, out_err, 0);
      check({tag, "_ready"}, in_ready, 1);
   endtask

   initial begin
      int cyc;
      int w;
      bq_t q;
      string pool;
      string ill;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // full-rate run: 11 chars + 2 result cycles
      run_str("1aF\015", 100, 100);
      run_stream(s2q("12345678 9\012"), 100, 100, cyc);
      check("throughput_cycles", cyc, 13);
      run_str("123456789\015", 100, 100);
      run_str("4g2 ", 100, 100);
      run_str("  \015\012AB ", 100, 100);
      run_str("7\0158\015", 100, -1);
      run_str("0x1F\015", 100, 100);
      run_str("0x\015", 100, 100);
      run_str("0x0x5 00x1 x \015", 100, 100);
      run_str("0X12345678 0x123456789 abcdef01\012", 70, 60);

      // reset in the middle of "12"
      @(negedge clk); in_valid = 1'b1; in_data = "1";
      @(negedge clk); in_data = "2";
      @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk); rst_n = 1'b1;
      #1;
      check("rst_mid_ready_after", in_ready, 1);
      run_str("\015", 100, 100);
      run_str("34\015", 100, 100);

      // reset while a result is waiting
      @(negedge clk); in_valid = 1'b1; in_data = "5"; out_ready = 1'b0;
      @(negedge clk); in_data = 8'h0D;
      @(negedge clk); in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 10) begin @(negedge clk); w++; end
      check("emit_before_rst", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_emit");
      @(negedge clk); rst_n = 1'b1;
      #1;
      check("rst_emit_ready_after", in_ready, 1);
      run_str("\015", 100, 100);

      // random streams
      pool = "0123456789abcdefABCDEF";
      ill  = "gxX.-zG";
      for (int r = 0; r < 4; r++) begin
         q.delete();
         for (int i = 0; i < 300; i++) begin
            w = $urandom % 100;
            if (w < 55) q.push_back(pool[$urandom % pool.len()]);
            else if (w < 75) begin
               case ($urandom % 3)
                  0: q.push_back(8'h0D);
                  1: q.push_back(8'h0A);
                  default: q.push_back(8'h20);
               endcase
            end else if (w < 85) q.push_back(ill[$urandom % ill.len()]);
            else begin
               q.push_back("0");
               q.push_back((($urandom % 2) == 0) ? 8'h78 : 8'h58);
            end
         end
         q.push_back(8'h0D);
         run_stream(q, 40 + 20 * r, 30 + 20 * r, cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
